nr_div_iter: RTL and testbench

- Iterative radix-2 non-restoring divider, one quotient bit per clock.
- Sits directly upstream of the rounding stage. It produces an unrounded WIDTH-bit quotient that includes the guard bits, plus the sign of the final remainder. The rounder consumes these to select round-to-nearest-even or round-toward-zero.
- The quotient is not corrected. A negative remainder tells the downstream rounder that q is one unit high.

---
 rtl/nr_div_iter.sv | 186 ++++++++++++++++++
 tb/tb_nr_div_iter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_div_iter.sv
// nr_div_iter
// Iterative radix-2 non-restoring divider producing one quotient bit per
// clock. The WIDTH-bit quotient (guard bits included) is left uncorrected:
// a negative final remainder tells the downstream rounder that q is one
// unit high.
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   rst_n           - synchronous active-low reset
//   in_valid        - operands x/d valid
//   in_ready        - divider idle and able to accept operands
//   x               - dividend, normalized (MSB set), x < 2*d
//   d               - divisor, normalized (MSB set) or zero
//   out_valid       - result valid, held until out_ready
//   out_ready       - downstream accepts the result
//   q               - unrounded, uncorrected quotient
//   rem_is_positive - final remainder > 0
//   rem_is_negative - final remainder < 0
//   exact           - final remainder is 0 or -D
//   div_by_zero     - divisor was zero
module nr_div_iter #(
  parameter int WIDTH = 28,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             rem_is_positive,
  output logic             rem_is_negative,
  output logic             exact,
  output logic             div_by_zero
);

  // Remainder needs a sign bit plus one bit of headroom for |R| < 2D.
  localparam int RW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       div_q, div_d;
  logic signed [RW-1:0]   rem_q, rem_d;
  // Only the quotient bits that survive into q are kept; the first bit
  // b_0 falls off the top because q = 2*B + 1 mod 2^WIDTH.
  logic [WIDTH-3:0]       bits_q, bits_d;
  logic                   zero_q, zero_d;
  logic [WIDTH-1:0]       quot_q, quot_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   exact_q, exact_d;
  logic                   dbz_q, dbz_d;

  logic signed [RW-1:0]   divExt;
  logic signed [RW-1:0]   remStep;
  logic                   stepBit;
  logic                   lastIter;

  // One non-restoring step: subtract when the partial remainder is
  // non-negative (quotient digit +1, stored as 1), add otherwise (digit -1,
  // stored as 0).
  always_comb begin
    divExt   = signed'({2'b00, div_q});
    stepBit  = ~rem_q[RW-1];
    remStep  = stepBit ? (rem_q - divExt) : (rem_q + divExt);
    lastIter = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero divisor still spends one cycle in BUSY so both
  // result paths reach DONE through the same BUSY->DONE edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (zero_q || lastIter) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: operand capture, iteration, and registering the
  // result flags on the final step.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    rem_d   = rem_q;
    bits_d  = bits_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    exact_d = exact_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d  = d;
          rem_d  = signed'({2'b00, x});
          bits_d = '0;
          cnt_d  = '0;
          zero_d = (d == '0);
        end
      end
      BUSY: begin
        if (zero_q) begin
          quot_d  = '1;
          pos_d   = 1'b0;
          neg_d   = 1'b0;
          exact_d = 1'b0;
          dbz_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          bits_d = {bits_q[WIDTH-4:0], stepBit};
          if (lastIter) begin
            // The final step is not doubled; q = 2*B + 1 mod 2^WIDTH maps
            // the {+1,-1} digit string onto a plain binary value.
            rem_d   = remStep;
            quot_d  = {bits_q, stepBit, 1'b1};
            pos_d   = ~remStep[RW-1] && (remStep != '0);
            neg_d   = remStep[RW-1];
            exact_d = (remStep == '0) || (remStep == -divExt);
            dbz_d   = 1'b0;
          end else begin
            rem_d = {remStep[RW-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; results are cleared by reset and otherwise held
  // through the DONE->IDLE handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      bits_q  <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      exact_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      bits_q  <= bits_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      exact_q <= exact_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q               = quot_q;
  assign rem_is_positive = pos_q;
  assign rem_is_negative = neg_q;
  assign exact           = exact_q;
  assign div_by_zero     = dbz_q;

endmodule

// File: tb/tb_nr_div_iter.sv
// tb_nr_div_iter
// Self-checking bench for nr_div_iter (WIDTH = 28). Expected results come
// from an arithmetic model: the exact integer quotient of X*2^27 / D is
// nudged to the unique odd q with -D <= R < D, which is what a
// non-restoring divider delivers without correction.
module tb_nr_div_iter;

  localparam int W = 28;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         rem_is_positive;
  logic         rem_is_negative;
  logic         exact;
  logic         div_by_zero;

  int checks;
  int errors;

  logic [W-1:0] expQ;
  logic         expPos;
  logic         expNeg;
  logic         expExact;
  logic         expDbz;

  nr_div_iter #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .x               (x),
    .d               (d),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .q               (q),
    .rem_is_positive (rem_is_positive),
    .rem_is_negative (rem_is_negative),
    .exact           (exact),
    .div_by_zero     (div_by_zero)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: floor quotient, then force it odd by stepping up one
  // unit (and the remainder down by D) when it is even.
  task automatic computeModel(input logic [W-1:0] xv, input logic [W-1:0] dv);
    longint num;
    longint den;
    longint quo;
    longint rmd;
    if (dv == '0) begin
      expQ     = '1;
      expPos   = 1'b0;
      expNeg   = 1'b0;
      expExact = 1'b0;
      expDbz   = 1'b1;
    end else begin
      num = {36'd0, xv};
      num = num << (W - 1);
      den = {36'd0, dv};
      quo = num / den;
      rmd = num - quo * den;
      if (quo[0] == 1'b0) begin
        quo = quo + 1;
        rmd = rmd - den;
      end
      expQ     = quo[W-1:0];
      expPos   = (rmd > 0);
      expNeg   = (rmd < 0);
      expExact = (rmd == 0) || (rmd == -den);
      expDbz   = 1'b0;
    end
  endtask

  // Wait (bounded) for in_ready, present one operand pair for one edge, then
  // leave junk on the inputs with in_valid high to show it is ignored.
  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] dv);
    int waitCycles;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("inReadyBeforeAccept", {31'd0, in_ready}, 32'd1);
    computeModel(xv, dv);
    x        = xv;
    d        = dv;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("inReadyBusy", {31'd0, in_ready}, 32'd0);
    x        = W'($urandom);
    d        = W'($urandom);
    in_valid = 1'b1;
  endtask

  // Count edges until out_valid (bounded), then compare latency and results.
  task automatic waitResult(input string tag, input int expLat);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput({tag, ".latency"}, cycles, expLat);
    checkOutput({tag, ".q"}, {4'd0, q}, {4'd0, expQ});
    checkOutput({tag, ".remPos"}, {31'd0, rem_is_positive}, {31'd0, expPos});
    checkOutput({tag, ".remNeg"}, {31'd0, rem_is_negative}, {31'd0, expNeg});
    checkOutput({tag, ".exact"}, {31'd0, exact}, {31'd0, expExact});
    checkOutput({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, expDbz});
  endtask

  // Accept the result on one edge; out_valid must fall, in_ready rise, and q
  // keep its value.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".validDrop"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, ".inReadyBack"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, ".qKept"}, {4'd0, q}, {4'd0, expQ});
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] rd;
    logic         sawValid;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    d         = '0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset.inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("reset.outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.q", {4'd0, q}, 32'd0);
    checkOutput("reset.flags",
                {28'd0, rem_is_positive, rem_is_negative, exact, div_by_zero},
                32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    applyStimulus(28'h8000000, 28'h8000000);
    waitResult("oneOverOne", 28);
    checkOutput("oneOverOne.qConst", {4'd0, q}, 32'h8000001);
    handshake("oneOverOne");

    applyStimulus(28'hC000000, 28'h8000000);
    waitResult("threeHalves", 28);
    checkOutput("threeHalves.qConst", {4'd0, q}, 32'hC000001);
    handshake("threeHalves");

    applyStimulus(28'h8000000, 28'hC000000);
    waitResult("twoThirds", 28);
    checkOutput("twoThirds.qConst", {4'd0, q}, 32'h5555555);
    handshake("twoThirds");

    applyStimulus(28'h8000000, 28'h0000000);
    waitResult("divZero", 1);
    checkOutput("divZero.qConst", {4'd0, q}, 32'hFFFFFFF);
    handshake("divZero");

    // Backpressure: hold out_ready low for 5 cycles
    applyStimulus(28'hA5A5A5A, 28'hF0F0F0F);
    waitResult("hold", 28);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold.qStable", {4'd0, q}, {4'd0, expQ});
      checkOutput("hold.validHeld", {31'd0, out_valid}, 32'd1);
      checkOutput("hold.inReadyLow", {31'd0, in_ready}, 32'd0);
    end
    handshake("hold");
    applyStimulus(28'hFFFFFFF, 28'h8000001);
    waitResult("afterHold", 28);
    handshake("afterHold");

    // Reset in the middle of a division
    applyStimulus(28'h8000000, 28'h8000000);
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawValid |= out_valid;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midReset.inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("midReset.q", {4'd0, q}, 32'd0);
    checkOutput("midReset.flags",
                {28'd0, rem_is_positive, rem_is_negative, exact, div_by_zero},
                32'd0);
    repeat (30) begin
      @(negedge clk);
      sawValid |= out_valid;
    end
    checkOutput("midReset.noValid", {31'd0, sawValid}, 32'd0);
    applyStimulus(28'hC000000, 28'h8000000);
    waitResult("postReset", 28);
    checkOutput("postReset.qConst", {4'd0, q}, 32'hC000001);
    handshake("postReset");

    // Random normalized operands, with the odd zero divisor and x == d
    for (int n = 0; n < 24; n++) begin
      rx = {1'b1, 27'($urandom)};
      rd = {1'b1, 27'($urandom)};
      if (n % 8 == 3) rd = rx;
      if (n % 8 == 6) rd = '0;
      applyStimulus(rx, rd);
      waitResult("random", (rd == '0) ? 1 : 28);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
